// File: rtl/cpu_sequencer.sv
// cpu_sequencer: three-state (IDLE/EXEC/WB) instruction sequencer that drives
// a register-file/ALU datapath for one instruction every three cycles.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   instr, instr_valid  40-bit instruction word and its valid strobe
//   instr_ready         high in IDLE: an instruction may be accepted
//   reg_*               register-file read/write controls and write data
//   b_source_select, alu_cin, alu_mode, alu_sel, alu_b_imm   ALU controls
//   alu_result, alu_cout  combinational returns from the datapath
//   done                one-cycle pulse in the WB cycle
//   flag_c, flag_z      carry/zero flags
//
// Optional feature: define CPU_SEQ_FLAGS_EN to build the flag registers;
// otherwise flag_c and flag_z are tied to 0.
//
// Instruction fields: [39] wb_en, [38] b_sel, [37] mode, [36] cin,
// [35:32] sel, [31:29] rd, [28:26] rs1, [25:23] rs2, [22:16] ignored,
// [15:0] imm.

module cpu_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [39:0]           instr,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   output logic                  reg_write_enable,
   output logic [ADDR_WIDTH-1:0] reg_read_addr1,
   output logic [ADDR_WIDTH-1:0] reg_read_addr2,
   output logic [ADDR_WIDTH-1:0] reg_write_addr,
   output logic [DATA_WIDTH-1:0] reg_write_data,
   output logic                  b_source_select,
   output logic                  alu_cin,
   output logic                  alu_mode,
   output logic [3:0]            alu_sel,
   output logic [DATA_WIDTH-1:0] alu_b_imm,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_cout,
   output logic                  done,
   output logic                  flag_c,
   output logic                  flag_z
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t                state;
   logic                  wb_en_q;
   logic [ADDR_WIDTH-1:0] rd_q;

`ifdef CPU_SEQ_FLAGS_EN
   logic                  cout_q;
`endif

   // Reserved instruction bits carry no function.
   logic unused_bits;
`ifdef CPU_SEQ_FLAGS_EN
   assign unused_bits = ^instr[22:16];
`else
   assign unused_bits = ^{instr[22:16], alu_cout};
   assign flag_c = 1'b0;
   assign flag_z = 1'b0;
`endif

   // Sequencer FSM with registered datapath controls. The control outputs
   // themselves act as the latched copy of the instruction fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         instr_ready      <= 1'b1;
         reg_write_enable <= 1'b0;
         done             <= 1'b0;
         reg_read_addr1   <= '0;
         reg_read_addr2   <= '0;
         reg_write_addr   <= '0;
         reg_write_data   <= '0;
         b_source_select  <= 1'b0;
         alu_cin          <= 1'b0;
         alu_mode         <= 1'b0;
         alu_sel          <= 4'h0;
         alu_b_imm        <= '0;
         wb_en_q          <= 1'b0;
         rd_q             <= '0;
`ifdef CPU_SEQ_FLAGS_EN
         cout_q           <= 1'b0;
         flag_c           <= 1'b0;
         flag_z           <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  wb_en_q         <= instr[39];
                  b_source_select <= instr[38];
                  alu_mode        <= instr[37];
                  alu_cin         <= instr[36];
                  alu_sel         <= instr[35:32];
                  rd_q            <= instr[31:29];
                  reg_read_addr1  <= instr[28:26];
                  reg_read_addr2  <= instr[25:23];
                  alu_b_imm       <= instr[15:0];
                  instr_ready     <= 1'b0;
                  state           <= EXEC;
               end
            end
            EXEC: begin
               // reg_write_data doubles as the result register.
               reg_write_data   <= alu_result;
               reg_write_addr   <= rd_q;
               reg_write_enable <= wb_en_q;
               done             <= 1'b1;
`ifdef CPU_SEQ_FLAGS_EN
               cout_q           <= alu_cout;
`endif
               state            <= WB;
            end
            WB: begin
               reg_write_enable <= 1'b0;
               done             <= 1'b0;
               instr_ready      <= 1'b1;
`ifdef CPU_SEQ_FLAGS_EN
               // Flags track every completed instruction, written or not.
               flag_c           <= cout_q;
               flag_z           <= (reg_write_data == '0);
`endif
               state            <= IDLE;
            end
            default: begin
               reg_write_enable <= 1'b0;
               done             <= 1'b0;
               instr_ready      <= 1'b1;
               state            <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: scoreboard of expected write-backs
// checked on every done pulse, plus per-scenario inline checks.

module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [39:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        reg_write_enable;
   logic [2:0]  reg_read_addr1, reg_read_addr2, reg_write_addr;
   logic [15:0] reg_write_data;
   logic        b_source_select, alu_cin, alu_mode;
   logic [3:0]  alu_sel;
   logic [15:0] alu_b_imm;
   logic [15:0] alu_result;
   logic        alu_cout;
   logic        done, flag_c, flag_z;

   // Datapath model: result = immediate + offset, carry driven by cout_in.
   logic [15:0] offset;
   logic        cout_in;
   assign alu_result = alu_b_imm + offset;
   assign alu_cout   = cout_in;

   typedef struct packed {
      logic        we;
      logic [2:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done   = 0;
   int   cyc      = 0;

   cpu_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .reg_write_enable(reg_write_enable),
      .reg_read_addr1(reg_read_addr1), .reg_read_addr2(reg_read_addr2),
      .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
      .b_source_select(b_source_select), .alu_cin(alu_cin),
      .alu_mode(alu_mode), .alu_sel(alu_sel), .alu_b_imm(alu_b_imm),
      .alu_result(alu_result), .alu_cout(alu_cout), .done(done),
      .flag_c(flag_c), .flag_z(flag_z)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [39:0] mk(input logic we, input logic bs,
                                      input logic md, input logic ci,
                                      input logic [3:0] sel, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [15:0] imm);
      return {we, bs, md, ci, sel, rd, rs1, rs2, 7'h55, imm};
   endfunction

   function automatic exp_t exp_of(input logic [39:0] w);
      exp_t e;
      e.we   = w[39];
      e.addr = w[31:29];
      e.data = w[15:0] + offset;
      return e;
   endfunction

   // Scoreboard monitor: every done pulse retires one expected write-back,
   // and a write enable is never allowed without done.
   always @(negedge clk) begin
      if (!reset) begin
         if (reg_write_enable && !done) begin
            n_checks++; n_fail++;
            $display("FAIL write_without_done: we=%0b done=%0b", reg_write_enable, done);
         end
         if (done) begin
            n_done++;
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_done: got done with empty scoreboard");
            end else begin
               exp_t e;
               exp_t got;
               e = q.pop_front();
               got.we = reg_write_enable; got.addr = reg_write_addr; got.data = reg_write_data;
               if (got !== e) begin
                  n_fail++;
                  $display("FAIL wb_scoreboard: got we=%0b addr=%0d data=%h, want we=%0b addr=%0d data=%h",
                           got.we, got.addr, got.data, e.we, e.addr, e.data);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // Present w, wait (bounded) for ready, then take it through the accept edge.
   task automatic issue(input logic [39:0] w);
      int t = 0;
      instr = w; instr_valid = 1'b1;
      while (!instr_ready && t < 20) begin step(1); t++; end
      if (!instr_ready) begin
         n_checks++; n_fail++;
         $display("FAIL issue_timeout: instr_ready=%0b after %0d cycles, want 1", instr_ready, t);
      end
      q.push_back(exp_of(w));
      step(1);
      instr_valid = 1'b0;
      instr = 40'($urandom());
   endtask

   task automatic test_reset;
      reset = 1'b1; instr_valid = 1'b1;
      instr = mk(1, 1, 1, 1, 4'hF, 3'd7, 3'd7, 3'd7, 16'hFFFF);
      step(2);
      chk("rst_ready", 16'(instr_ready), 16'h1);
      chk("rst_we_done", 16'({reg_write_enable, done}), 16'h0);
      chk("rst_flags", 16'({flag_c, flag_z}), 16'h0);
      chk("rst_addrs", 16'({reg_read_addr1, reg_read_addr2, reg_write_addr}), 16'h0);
      chk("rst_wdata", reg_write_data, 16'h0);
      chk("rst_ctrl", 16'({b_source_select, alu_cin, alu_mode, alu_sel}), 16'h0);
      chk("rst_imm", alu_b_imm, 16'h0);
      instr_valid = 1'b0; reset = 1'b0;
      step(2);
      chk("idle_hold_ready", 16'(instr_ready), 16'h1);
      chk("idle_hold_imm", alu_b_imm, 16'h0);
   endtask

   task automatic test_basic;
      offset = 16'h0003; cout_in = 1'b0;
      issue(mk(1, 1, 0, 0, 4'h9, 3'd2, 3'd1, 3'd0, 16'h0005));
      chk("exec_ready", 16'(instr_ready), 16'h0);
      chk("exec_raddr1", 16'(reg_read_addr1), 16'h1);
      chk("exec_raddr2", 16'(reg_read_addr2), 16'h0);
      chk("exec_ctrl", 16'({b_source_select, alu_cin, alu_mode, alu_sel}), 16'h49);
      chk("exec_imm", alu_b_imm, 16'h0005);
      chk("exec_we_done", 16'({reg_write_enable, done}), 16'h0);
      step(1);
      chk("wb_we_done", 16'({reg_write_enable, done}), 16'h3);
      chk("wb_addr", 16'(reg_write_addr), 16'h2);
      chk("wb_data", reg_write_data, 16'h0008);
      chk("wb_ctrl_held", 16'({b_source_select, alu_sel}), 16'h19);
      step(1);
      chk("post_wb_we_done", 16'({reg_write_enable, done}), 16'h0);
      chk("post_wb_ready", 16'(instr_ready), 16'h1);
      chk("post_wb_data_held", reg_write_data, 16'h0008);
   endtask

   task automatic test_no_wb;
      offset = 16'h0003;
      issue(mk(0, 1, 0, 0, 4'h9, 3'd2, 3'd1, 3'd0, 16'h0005));
      chk("nowb_exec_we", 16'(reg_write_enable), 16'h0);
      step(1);
      chk("nowb_wb_we_done", 16'({reg_write_enable, done}), 16'h1);
      step(1);
      chk("nowb_after_we_done", 16'({reg_write_enable, done}), 16'h0);
   endtask

   task automatic test_back_to_back;
      logic [39:0] w[3];
      int acc[3];
      int k = 0, lows = 0, t = 0;
      offset = 16'h0100;
      w[0] = mk(1, 0, 1, 0, 4'h1, 3'd4, 3'd5, 3'd6, 16'h1111);
      w[1] = mk(1, 1, 0, 1, 4'h2, 3'd5, 3'd6, 3'd7, 16'h2222);
      w[2] = mk(0, 0, 0, 0, 4'h3, 3'd6, 3'd0, 3'd1, 16'h3333);
      instr = w[0]; instr_valid = 1'b1;
      while (k < 3 && t < 40) begin
         if (instr_ready) begin
            q.push_back(exp_of(w[k]));
            @(posedge clk); acc[k] = cyc; k++; #1;
            if (k < 3) instr = w[k]; else instr_valid = 1'b0;
         end else begin
            lows++;
            step(1);
         end
         t++;
      end
      instr_valid = 1'b0;
      chk("b2b_accepts", 16'(k), 16'd3);
      if (k == 3) begin
         chk("b2b_gap01", 16'(acc[1] - acc[0]), 16'd3);
         chk("b2b_gap12", 16'(acc[2] - acc[1]), 16'd3);
      end
      chk("b2b_ready_low", 16'(lows), 16'd4);
      step(3);
   endtask

   task automatic test_reset_exec;
      int d0;
      offset = 16'h0001;
      issue(mk(1, 0, 0, 0, 4'h4, 3'd1, 3'd2, 3'd3, 16'h00AA));
      void'(q.pop_back());
      d0 = n_done;
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("rexec_ready", 16'(instr_ready), 16'h1);
      chk("rexec_we_done", 16'({reg_write_enable, done}), 16'h0);
      step(3);
      chk("rexec_no_done", 16'(n_done - d0), 16'h0);
   endtask

   task automatic test_hazard;
      offset = 16'h0042;
      issue(mk(1, 1, 0, 1, 4'h6, 3'd3, 3'd3, 3'd3, 16'h0700));
      chk("haz_raddr1", 16'(reg_read_addr1), 16'h3);
      // Changing instr/instr_valid mid-instruction must have no effect.
      instr = mk(1, 0, 1, 0, 4'hA, 3'd7, 3'd7, 3'd7, 16'hDEAD); instr_valid = 1'b1;
      step(1);
      instr_valid = 1'b0;
      chk("haz_waddr", 16'(reg_write_addr), 16'h3);
      chk("haz_wdata", reg_write_data, 16'h0742);
      chk("haz_imm_held", alu_b_imm, 16'h0700);
      step(1);
      chk("haz_idle_ready", 16'(instr_ready), 16'h1);
   endtask

   task automatic test_flags;
      offset = 16'h0003; cout_in = 1'b1;
      issue(mk(0, 1, 0, 0, 4'h0, 3'd1, 3'd1, 3'd1, 16'hFFFD));
      step(2);
`ifdef CPU_SEQ_FLAGS_EN
      chk("flags_set", 16'({flag_c, flag_z}), 16'h3);
`else
      chk("flags_tied_a", 16'({flag_c, flag_z}), 16'h0);
`endif
      cout_in = 1'b0;
      issue(mk(1, 1, 0, 0, 4'h0, 3'd2, 3'd1, 3'd1, 16'h1231));
      step(2);
      chk("flags_clear", 16'({flag_c, flag_z}), 16'h0);
   endtask

   initial begin
      instr = '0; instr_valid = 1'b0; reset = 1'b1;
      offset = '0; cout_in = 1'b0;
      test_reset();
      test_basic();
      test_no_wb();
      test_back_to_back();
      test_reset_exec();
      test_hazard();
      test_flags();
      step(2);
      chk("scoreboard_drained", 16'(q.size()), 16'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
